miter_seq_cmp: RTL

- Parametrised, clocked successor to the combinational equivalence-compare property used in the EQY miters.
- Compares CHANNELS independent gold/gate buses of WIDTH bits every enabled cycle, with gold-X treated as don't-care.
- Suppresses checks during a settle window after reset, then latches the first failure (channel and cycle) and counts mismatches.
- Sits inside miter modules between the gold and gate instances and drives assert/assume/cover on the registered verdict.

---
 rtl/miter_pkg.sv | 22 ++
 rtl/miter_chan_cmp.sv | 22 ++
 rtl/miter_seq_cmp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/miter_pkg.sv
// Shared types and helpers for the sequential equivalence-compare miter.
// Holds the FSM encoding, the property-kind names and the index-width helper.
package miter_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2,
    ST_RSVD   = 2'd3
  } state_t;

  localparam string TYPE_ASSERT = "assert";
  localparam string TYPE_ASSUME = "assume";
  localparam string TYPE_COVER  = "cover";
  localparam string TYPE_NONE   = "none";

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miter_chan_cmp.sv
// X-aware compare of one gold/gate channel; a gold bit that is X is a don't-care.
// Comparison is 4-state, so an X on the gate side against a known gold bit fails.
module miter_chan_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gate,
  output logic             ok
);

  logic [WIDTH-1:0] bit_ok;

  always_comb begin
    bit_ok = '0;
    for (int b = 0; b < WIDTH; b++) begin
      bit_ok[b] = (gold[b] === 1'bx) || (gold[b] === gate[b]);
    end
  end

  assign ok = &bit_ok;

endmodule

// File: rtl/miter_seq_cmp.sv
// Clocked equivalence compare for EQY miters: settle window, registered verdict,
// sticky first-failure capture and a saturating mismatch counter.
module miter_seq_cmp
  import miter_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    CHANNELS = 4,
  parameter int    SETTLE   = 2,
  parameter int    CNT_W    = 16,
  parameter string TYPE     = "assert"
) (
  input  logic                        __pi_clk,
  input  logic                        __pi_rst,
  input  logic                        en,
  input  logic [CHANNELS*WIDTH-1:0]   in_gold,
  input  logic [CHANNELS*WIDTH-1:0]   in_gate,
  output logic                        okay,
  output logic                        fail,
  output logic [idx_w(CHANNELS)-1:0]  fail_chan,
  output logic [CNT_W-1:0]            fail_cycle,
  output logic [CNT_W-1:0]            mismatch_cnt,
  output logic [1:0]                  state
);

  localparam int CHAN_W = idx_w(CHANNELS);
  localparam int SET_W  = idx_w(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_t RST_STATE = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t               state_q;
  state_t               state_d;
  logic [SET_W-1:0]     settle_cnt;
  logic [CNT_W-1:0]     cycle_cnt;
  logic [CHANNELS-1:0]  chan_ok_p0;
  logic                 cyc_ok_p0;
  logic [CHAN_W-1:0]    first_idx_p0;
  logic                 vld_p0;
  logic                 first_fail_p0;

  // ---- p0: combinational compare of the current inputs ----
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    miter_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
      .gold (in_gold[c*WIDTH +: WIDTH]),
      .gate (in_gate[c*WIDTH +: WIDTH]),
      .ok   (chan_ok_p0[c])
    );
  end

  assign cyc_ok_p0 = &chan_ok_p0;

  // Scan from the top so the lowest failing index wins.
  always_comb begin
    first_idx_p0 = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (!chan_ok_p0[c]) first_idx_p0 = CHAN_W'(c);
    end
  end

  assign vld_p0        = en && ((state_q == ST_CHECK) || (state_q == ST_FAIL));
  assign first_fail_p0 = en && (state_q == ST_CHECK) && !cyc_ok_p0;

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_CHECK;
        ST_CHECK:  if (!cyc_ok_p0) state_d = ST_FAIL;
        ST_FAIL:   state_d = ST_FAIL;
        default:   state_d = ST_CHECK;
      endcase
    end
  end

  always_ff @(posedge __pi_clk or posedge __pi_rst) begin
    if (__pi_rst) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  // ---- p1: registered verdict, counters and first-failure capture ----
  always_ff @(posedge __pi_clk or posedge __pi_rst) begin
    if (__pi_rst) begin
      settle_cnt   <= '0;
      cycle_cnt    <= '0;
      okay         <= 1'b1;
      fail         <= 1'b0;
      fail_chan    <= '0;
      fail_cycle   <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (en && (state_q == ST_SETTLE)) settle_cnt <= settle_cnt + SET_W'(1);
      if (vld_p0) begin
        okay      <= cyc_ok_p0;
        cycle_cnt <= sat_inc(cycle_cnt);
        if (!cyc_ok_p0) mismatch_cnt <= sat_inc(mismatch_cnt);
      end
      if (first_fail_p0) begin
        fail       <= 1'b1;
        fail_chan  <= first_idx_p0;
        fail_cycle <= cycle_cnt;
      end
    end
  end

  assign state = state_q;

  // Properties observe the registered verdict, never the raw compare.
  if (TYPE == TYPE_ASSERT) begin : g_assert
    a_okay: assert property (@(posedge __pi_clk) disable iff (__pi_rst)
                             (okay || (state_q == ST_SETTLE)));
  end else if (TYPE == TYPE_ASSUME) begin : g_assume
    m_okay: assume property (@(posedge __pi_clk) disable iff (__pi_rst)
                             (okay || (state_q == ST_SETTLE)));
  end else if (TYPE == TYPE_COVER) begin : g_cover
    c_fail: cover property (@(posedge __pi_clk) disable iff (__pi_rst) fail);
  end

endmodule
